// File: rtl/unary_frame_tx.sv
// unary_frame_tx: regenerates a thermometer word from a ones count and sends it LSB-first.
// Define UNARY_TX_PARITY_EN to append an even-parity bit to every frame.
module unary_frame_tx #(
    parameter int WIDTH = 8,
    parameter int CW    = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [CW-1:0]    cnt_in,
    input  logic             cnt_valid,
    output logic             cnt_ready,
    output logic [WIDTH-1:0] therm_out,
    output logic             therm_valid,
    output logic             bit_out,
    output logic             bit_valid,
    output logic             frame_start,
    output logic             frame_end,
    output logic             cnt_err
);
    typedef enum logic [1:0] {
        IDLE,
        SEND
`ifdef UNARY_TX_PARITY_EN
        , PAR
`endif
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] shift_q, shift_d, therm_q, therm_d, therm_new;
    logic [CW-1:0]    idx_q, idx_d, c;
    logic             therm_valid_q, therm_valid_d, cnt_err_q, cnt_err_d;
    logic             bit_out_q, bit_out_d, bit_valid_q, bit_valid_d;
    logic             frame_start_q, frame_start_d, frame_end_q, frame_end_d;
    logic             accept, last;
`ifdef UNARY_TX_PARITY_EN
    logic             par_q, par_d;
`endif

    // frame_end_q marks the only frame cycle on which a new count may be taken
    assign cnt_ready = (state_q == IDLE) | frame_end_q;
    assign accept    = cnt_valid & cnt_ready;
    assign c         = (cnt_in > CW'(WIDTH)) ? CW'(WIDTH) : cnt_in;
    assign therm_new = ~({WIDTH{1'b1}} << c);
    assign last      = idx_q == CW'(WIDTH - 1);

    always_comb begin
        state_d       = state_q;
        shift_d       = shift_q >> 1;
        idx_d         = idx_q + 1'b1;
        therm_d       = therm_q;
        therm_valid_d = accept;
        cnt_err_d     = accept & (cnt_in > CW'(WIDTH));
        bit_out_d     = shift_q[0];
        bit_valid_d   = 1'b1;
        frame_start_d = 1'b0;
`ifdef UNARY_TX_PARITY_EN
        frame_end_d   = 1'b0;
        par_d         = par_q;
`else
        frame_end_d   = idx_q == CW'(WIDTH - 2);
`endif
        if (accept) begin
            state_d       = SEND;
            shift_d       = therm_new >> 1;
            idx_d         = '0;
            therm_d       = therm_new;
            bit_out_d     = therm_new[0];
            frame_start_d = 1'b1;
            frame_end_d   = 1'b0;
`ifdef UNARY_TX_PARITY_EN
            par_d         = c[0];
`endif
        end else if (state_q == SEND && last) begin
`ifdef UNARY_TX_PARITY_EN
            state_d     = PAR;
            bit_out_d   = par_q;
            frame_end_d = 1'b1;
`else
            state_d     = IDLE;
            bit_out_d   = 1'b0;
            bit_valid_d = 1'b0;
            frame_end_d = 1'b0;
`endif
        end else if (state_q != SEND) begin
            state_d     = IDLE;
            bit_out_d   = 1'b0;
            bit_valid_d = 1'b0;
            frame_end_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            shift_q       <= '0;
            idx_q         <= '0;
            therm_q       <= '0;
            therm_valid_q <= 1'b0;
            cnt_err_q     <= 1'b0;
            bit_out_q     <= 1'b0;
            bit_valid_q   <= 1'b0;
            frame_start_q <= 1'b0;
            frame_end_q   <= 1'b0;
`ifdef UNARY_TX_PARITY_EN
            par_q         <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            shift_q       <= shift_d;
            idx_q         <= idx_d;
            therm_q       <= therm_d;
            therm_valid_q <= therm_valid_d;
            cnt_err_q     <= cnt_err_d;
            bit_out_q     <= bit_out_d;
            bit_valid_q   <= bit_valid_d;
            frame_start_q <= frame_start_d;
            frame_end_q   <= frame_end_d;
`ifdef UNARY_TX_PARITY_EN
            par_q         <= par_d;
`endif
        end
    end

    assign therm_out   = therm_q;
    assign therm_valid = therm_valid_q;
    assign cnt_err     = cnt_err_q;
    assign bit_out     = bit_out_q;
    assign bit_valid   = bit_valid_q;
    assign frame_start = frame_start_q;
    assign frame_end   = frame_end_q;
endmodule

// File: tb/tb_unary_frame_tx.sv
// tb_unary_frame_tx: checks unary_frame_tx against a frame-queue reference model.
module tb_unary_frame_tx;
    localparam int WIDTH = 8;
    localparam int CW    = 4;
`ifdef UNARY_TX_PARITY_EN
    localparam bit PAR = 1'b1;
`else
    localparam bit PAR = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [CW-1:0]    cnt_in = '0;
    logic             cnt_valid = 1'b0;
    logic             cnt_ready, therm_valid, bit_out, bit_valid;
    logic             frame_start, frame_end, cnt_err;
    logic [WIDTH-1:0] therm_out;

    int checks = 0;
    int errors = 0;
    int q[$];
    int pos = 0;
    int m_therm = 0;
    bit m_tv = 1'b0;
    bit m_err = 1'b0;

    unary_frame_tx #(.WIDTH(WIDTH), .CW(CW)) dut (
        .clk(clk), .rst(rst), .cnt_in(cnt_in), .cnt_valid(cnt_valid),
        .cnt_ready(cnt_ready), .therm_out(therm_out), .therm_valid(therm_valid),
        .bit_out(bit_out), .bit_valid(bit_valid), .frame_start(frame_start),
        .frame_end(frame_end), .cnt_err(cnt_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q = {};
        pos = 0;
        m_therm = 0;
        m_tv = 1'b0;
        m_err = 1'b0;
    endtask

    // Check outputs now, then apply inputs and predict the coming rising edge.
    task automatic cyc(input bit v, input int c);
        bit acc;
        int cl;
        chk("cnt_ready", cnt_ready, q.size() <= 1);
        chk("bit_valid", bit_valid, q.size() > 0);
        chk("bit_out", bit_out, q.size() > 0 ? q[0] : 0);
        chk("frame_start", frame_start, q.size() > 0 && pos == 0);
        chk("frame_end", frame_end, q.size() == 1);
        chk("therm_out", therm_out, m_therm);
        chk("therm_valid", therm_valid, m_tv);
        chk("cnt_err", cnt_err, m_err);
        cnt_valid = v;
        cnt_in = CW'(c);
        if (rst) model_reset();
        else begin
            acc = v && q.size() <= 1;
            if (q.size() > 0) begin
                void'(q.pop_front());
                pos++;
            end
            m_tv = acc;
            m_err = acc && c > WIDTH;
            if (acc) begin
                cl = c > WIDTH ? WIDTH : c;
                q = {};
                for (int i = 0; i < WIDTH; i++) q.push_back(i < cl ? 1 : 0);
                if (PAR) q.push_back(cl % 2);
                pos = 0;
                m_therm = (1 << cl) - 1;
            end
        end
        @(negedge clk);
    endtask

    initial begin
        model_reset();
        @(negedge clk);
        cyc(0, 0);
        cyc(1, 7);
        rst = 1'b0;
        cyc(0, 0);
        // single count of 3
        cyc(1, 3);
        repeat (11) cyc(0, 0);
        // 0 then 8 with valid held
        cyc(1, 0);
        repeat (WIDTH + PAR - 1) cyc(1, 0);
        cyc(1, 8);
        repeat (WIDTH + PAR + 2) cyc(0, 0);
        // over-range count clamps
        cyc(1, 12);
        repeat (WIDTH + PAR + 2) cyc(0, 0);
        // request held mid-frame waits for the final frame cycle
        cyc(1, 2);
        repeat (3) cyc(0, 0);
        repeat (8) cyc(1, 5);
        repeat (WIDTH + 3) cyc(0, 0);
        cyc(1, 4);
        repeat (WIDTH + 3) cyc(0, 0);
        // asynchronous reset mid-frame after three bits
        cyc(1, 6);
        repeat (3) cyc(0, 0);
        rst = 1'b1;
        #1;
        model_reset();
        cyc(0, 0);
        cyc(1, 3);
        rst = 1'b0;
        cyc(0, 0);
        // random traffic
        repeat (400) cyc(($urandom % 4) != 0, int'($urandom_range(0, 15)));
        repeat (WIDTH + 3) cyc(0, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
